// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS fetch front end.
//                Holds the datapath width, the NOP encoding, the default
//                fetch-queue depth and the packed queue-entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Instruction and PC width.
    localparam int XLEN = 32;

    // Default number of fetch-queue entries.
    localparam int DEFAULT_DEPTH = 4;

    // Encoding presented to decode when the queue is empty (sll $0,$0,0).
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [XLEN-1:0] word_t;

    // One queue entry: instruction word in the upper half, its PC+4 below.
    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic fetch_entry_t make_entry(input word_t instr, input word_t pc_plus4);
        fetch_entry_t e;
        e.instr    = instr;
        e.pc_plus4 = pc_plus4;
        return e;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Circular entry store for the fetch queue. Power-of-two
//                depth; pointers wrap naturally modulo DEPTH. A flush clears
//                pointers and occupancy in one edge; storage is not cleared.
//  Ports       : clk    - clock, all state updates on its rising edge
//                push   - write wdata at the write pointer
//                pop    - retire the head entry
//                flush  - return to empty (also serves as the reset path)
//                wdata  - entry to write
//                rdata  - head entry (combinational)
//                count  - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [ENTRY_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic               w_do_pop;
    logic               w_do_push;

    // Protect the occupancy counter against a pop on empty or a push on
    // full; a push on full is only legal when the head leaves the same edge.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Decoupled instruction fetch stage. Issues word fetches to a
//                one-cycle-latency instruction memory, captures each response
//                together with its PC+4 into a small queue, and presents the
//                head entry to decode. A taken branch flushes the queue,
//                drops any in-flight response and redirects the fetch PC.
//  Ports       : Clk, Rst           - clock, synchronous active-high reset
//                Stall              - decode cannot accept, hold head entry
//                BranchTaken/Target - redirect from the memory stage
//                ImemRdAddr/ImemReq - fetch request (word address)
//                ImemRdData         - response, one cycle after ImemReq
//                InstructionD       - head instruction (NOP when empty)
//                PCPlus4D           - head PC+4 (0 when empty)
//                ValidD             - head entry is valid
//                PCF                - current fetch PC
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import mips_pkg::*;
#(
    parameter int              DEPTH = DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] NOP   = NOP_INSTR
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    output logic [XLEN-3:0] ImemRdAddr,
    output logic            ImemReq,
    input  logic [XLEN-1:0] ImemRdData,
    output logic [XLEN-1:0] InstructionD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [XLEN-1:0] PCF
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Elaboration-time guard on the queue geometry.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("fetch_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [XLEN-1:0]    r_pcf;
    logic [XLEN-1:0]    r_tag;
    logic               r_inflight;

    logic [CW-1:0]      w_count;
    logic [CW:0]        w_committed;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic [XLEN-1:0]    w_pc_next;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    fetch_entry_t       w_head;

    // Issue credit: an outstanding request already owns a slot, so counting
    // it here guarantees the capture edge always finds space.
    assign w_committed = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = !Rst && !BranchTaken && (w_committed < (CW+1)'(DEPTH));

    // Reset shares the flush path into the entry store so pointers and
    // occupancy clear with the rest of the fetch state.
    assign w_flush     = Rst || BranchTaken;
    assign w_push      = r_inflight && !w_flush;
    assign w_pop       = ValidD && !Stall && !w_flush;

    assign w_pc_next   = r_pcf + 32'd4;
    assign w_wdata     = make_entry(ImemRdData, r_tag);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .count (w_count)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pcf      <= '0;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else if (BranchTaken) begin
            // The tag is left alone: with inflight cleared it is never used.
            r_pcf      <= BranchTarget;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pcf <= w_pc_next;
                r_tag <= w_pc_next;
            end
        end
    end

    assign w_head       = fetch_entry_t'(w_rdata);

    assign ValidD       = (w_count != '0);
    assign InstructionD = ValidD ? w_head.instr    : NOP;
    assign PCPlus4D     = ValidD ? w_head.pc_plus4 : '0;

    // Low two bits of the PC (e.g. from an unaligned branch target) never
    // reach the word address.
    assign ImemRdAddr   = r_pcf[XLEN-1:2];
    assign ImemReq      = w_issue;
    assign PCF          = r_pcf;

endmodule : fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter NOP, default 32'h0000_0000, instruction word presented when the queue is empty.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  decode cannot accept; the head entry SHALL be held.
REQ-006 BranchTaken  input  1  branch resolved taken in the memory stage (PCSrcM).
REQ-007 BranchTarget  input  32  redirect address (PCBranchM).
REQ-008 ImemRdAddr  output  30  word address to instruction memory (PCF[31:2]).
REQ-009 ImemReq  output  1  fetch issued this cycle.
REQ-010 ImemRdData  input  32  instruction word, valid exactly 1 cycle after ImemReq.
REQ-011 InstructionD  output  32  head instruction to decode.
REQ-012 PCPlus4D  output  32  PC+4 of the head instruction.
REQ-013 ValidD  output  1  head entry is valid.
REQ-014 PCF  output  32  current fetch PC (drives the Test port).

Function
REQ-015 Fetch issue: ImemReq=1 when (count + inflight) < DEPTH and BranchTaken=0; on issue PCF SHALL advance by 4.
REQ-016 inflight (0/1) SHALL mark a request issued last cycle. A tag register SHALL hold that request's PC+4.
REQ-017 Push: when inflight=1 and no flush, {ImemRdData, tag} SHALL be written at the write pointer; space is guaranteed by REQ-015.
REQ-018 Pop: when ValidD=1 and Stall=0, the read pointer SHALL advance in the same cycle. Push and pop in one cycle SHALL leave count unchanged.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-020 Outputs SHALL be driven combinationally from the head entry. When count=0: ValidD=0, InstructionD=NOP, PCPlus4D=0.
REQ-021 Latency: after reset or flush, the first instruction SHALL appear at ValidD on the 2nd rising edge after issue (issue edge, then capture edge).
REQ-022 Flush: when BranchTaken=1, the next edge SHALL do all of the following:
- count=0 and pointers=0;
- inflight=0, so any in-flight response is discarded;
- PCF=BranchTarget;
- no push and no pop.
Flush SHALL take priority over Stall, push and pop.
REQ-023 While Stall=1 with no flush, InstructionD, PCPlus4D and ValidD SHALL stay stable. Fetching SHALL continue until the queue is full, then ImemReq SHALL be 0.
REQ-024 BranchTarget SHALL be used unmodified; bits [1:0] SHALL be ignored when forming ImemRdAddr.
REQ-025 PCF arithmetic SHALL wrap modulo 2^32.

Reset
REQ-026 On Rst=1 at an edge, the next state SHALL be:
- PCF=0;
- count=0 and pointers=0;
- inflight=0 and tag=0.
Therefore ImemReq=0 during reset and ValidD=0/InstructionD=NOP afterwards.
REQ-027 Rst SHALL override BranchTaken and Stall. A response arriving after a mid-operation reset SHALL be discarded.
REQ-028 Storage array contents need not be reset.

Structure
REQ-029 NOP encoding, default DEPTH and the 32-bit instruction/PC widths SHALL live in the shared package mips_pkg.
REQ-030 Entry storage and pointers SHALL be a sub-module fetch_fifo. Its ports SHALL be: push, pop, flush, wdata[63:0], rdata[63:0], count.
REQ-031 fetch_queue SHALL own PCF, inflight, the tag register and the issue credit logic.

Verification
REQ-032 Cold start: release Rst, Stall=0, memory returns word = 32'hA000_0000 | addr.
- Expect ImemRdAddr sequence 0,1,2,...
- Expect ValidD=1 from the 2nd edge, with InstructionD=32'hA000_0000 and PCPlus4D=4, then 32'hA000_0001 and 8 on successive cycles.
REQ-033 Stall fill: hold Stall=1 from the first valid cycle.
- Expect count to reach 4 and ImemReq=0 thereafter.
- Expect InstructionD held at 32'hA000_0000.
- On Stall release, expect entries 0..3 popped in order with no gap.
REQ-034 Flush with in-flight request: assert BranchTaken=1 with BranchTarget=32'h0000_0100 while inflight=1.
- Expect ValidD=0 next cycle and the in-flight word dropped.
- Expect the next ImemRdAddr to be 30'h40, and PCPlus4D=32'h104 for the first new instruction.
REQ-035 Simultaneous push/pop at count=3 with Stall=0: expect count to stay 3 and order to be preserved across pointer wrap (write pointer 3 -> 0).
REQ-036 Mid-operation reset: assert Rst for one cycle with queue full and BranchTaken=1.
- Expect PCF=0, not BranchTarget.
- Expect ValidD=0 and InstructionD=32'h0, and the fetch sequence to restart at address 0.
